// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: FSM encodings, parameter
// defaults and the per-stage control word.
package pipe_ctrl_pkg;

   localparam int unsigned STATE_W              = 2;
   localparam int unsigned CD_W                 = 4;   // countdown width, covers 1..15
   localparam int unsigned RST_STALL_CYCLES_DEF = 2;
   localparam int unsigned CNT_W_DEF            = 16;

   localparam logic [1:0] S_RESET    = 2'd0;
   localparam logic [1:0] S_RUN      = 2'd1;
   localparam logic [1:0] S_MEM_WAIT = 2'd2;

   // Per-stage control word driven to the datapath
   typedef struct packed {
      logic rst_stall;
      logic pc_en;
      logic if_id_en;
      logic if_id_flush;
      logic id_ex_en;
      logic id_ex_bubble;
      logic ex_mem_en;
      logic mem_wb_en;
      logic mem_wb_bubble;
   } stage_ctrl_t;

   localparam stage_ctrl_t CTRL_RESET = '{
      rst_stall: 1'b1, pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b1,
      id_ex_en: 1'b1, id_ex_bubble: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1,
      mem_wb_bubble: 1'b0};

   localparam stage_ctrl_t CTRL_RUN = '{
      rst_stall: 1'b0, pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0,
      id_ex_en: 1'b1, id_ex_bubble: 1'b0, ex_mem_en: 1'b1, mem_wb_en: 1'b1,
      mem_wb_bubble: 1'b0};

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/control bundle between the core and the pipeline sequencer.
//   master: core side, drives stall/redirect/memory-ready requests
//   slave : pipe_ctrl side, drives stage enables, flushes, bubbles and debug
interface pipe_ctrl_if #(parameter int unsigned CNT_W = 16);

   logic             i_load_use_stall;
   logic             i_id_redirect;
   logic             i_imem_ready;
   logic             i_dmem_req;
   logic             i_dmem_ready;
   logic             o_rst_stall;
   logic             o_pc_en;
   logic             o_if_id_en;
   logic             o_if_id_flush;
   logic             o_id_ex_en;
   logic             o_id_ex_bubble;
   logic             o_ex_mem_en;
   logic             o_mem_wb_en;
   logic             o_mem_wb_bubble;
   logic [1:0]       o_state;
   logic [CNT_W-1:0] o_stall_cycles;

   modport master (
      output i_load_use_stall, i_id_redirect, i_imem_ready, i_dmem_req, i_dmem_ready,
      input  o_rst_stall, o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_en,
             o_id_ex_bubble, o_ex_mem_en, o_mem_wb_en, o_mem_wb_bubble,
             o_state, o_stall_cycles
   );

   modport slave (
      input  i_load_use_stall, i_id_redirect, i_imem_ready, i_dmem_req, i_dmem_ready,
      output o_rst_stall, o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_en,
             o_id_ex_bubble, o_ex_mem_en, o_mem_wb_en, o_mem_wb_bubble,
             o_state, o_stall_cycles
   );

endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous clear.
//   i_clk, i_rst : clock, async active-high clear
//   i_inc        : count this cycle
//   o_count      : current value, sticks at all-ones
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_inc,
   output logic [W-1:0] o_count
);

   logic [W-1:0] count_q, count_d;

   // Increment unless already at all-ones
   always_comb begin
      count_d = count_q;
      if (i_inc && (count_q != {W{1'b1}})) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) count_q <= '0;
      else       count_q <= count_d;
   end

   assign o_count = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer: turns stall/redirect/memory handshakes into
// per-stage enable, flush and bubble controls, holds the pipeline after
// reset and counts stall cycles.
//   i_clk, i_rst : core clock, async active-high reset
//   bus          : request inputs and stage-control outputs (pipe_ctrl_if.slave)
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned RST_STALL_CYCLES = RST_STALL_CYCLES_DEF,
   parameter int unsigned CNT_W            = CNT_W_DEF
) (
   input  logic        i_clk,
   input  logic        i_rst,
   pipe_ctrl_if.slave  bus
);

   localparam logic [CD_W-1:0] CD_INIT = CD_W'(RST_STALL_CYCLES - 1);

   logic [STATE_W-1:0] state_q, state_d;
   logic [CD_W-1:0]    cd_q, cd_d;
   stage_ctrl_t        ctrl;
   logic               freeze;
   logic               stall_inc;

   assign freeze = bus.i_dmem_req & ~bus.i_dmem_ready;

   // State and post-reset countdown registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_RESET;
         cd_q    <= CD_INIT;
      end else begin
         state_q <= state_d;
         cd_q    <= cd_d;
      end
   end

   // Next state and stage controls; priority freeze > load-use > redirect > imem-wait
   always_comb begin
      state_d = state_q;
      cd_d    = cd_q;
      ctrl    = CTRL_RESET;
      case (state_q)
         S_RESET: begin
            if (cd_q == '0) state_d = S_RUN;
            else            cd_d    = cd_q - CD_W'(1);
         end
         S_RUN, S_MEM_WAIT: begin
            ctrl    = CTRL_RUN;
            state_d = S_RUN;
            if (freeze) begin
               ctrl.pc_en         = 1'b0;
               ctrl.if_id_en      = 1'b0;
               ctrl.id_ex_en      = 1'b0;
               ctrl.ex_mem_en     = 1'b0;
               ctrl.mem_wb_en     = 1'b0;
               ctrl.mem_wb_bubble = 1'b1;
               state_d            = S_MEM_WAIT;
            end else if (bus.i_load_use_stall) begin
               // Redirect is ignored: a branch on a pending load is unresolved
               ctrl.pc_en        = 1'b0;
               ctrl.if_id_en     = 1'b0;
               ctrl.id_ex_bubble = 1'b1;
            end else if (bus.i_id_redirect) begin
               // PC takes the target even without imem data; wrong path is dropped
               ctrl.if_id_flush = 1'b1;
            end else if (!bus.i_imem_ready) begin
               ctrl.pc_en       = 1'b0;
               ctrl.if_id_flush = 1'b1;
            end
         end
         default: begin
            state_d = S_RESET;
            cd_d    = CD_INIT;
         end
      endcase
   end

   assign bus.o_rst_stall     = ctrl.rst_stall;
   assign bus.o_pc_en         = ctrl.pc_en;
   assign bus.o_if_id_en      = ctrl.if_id_en;
   assign bus.o_if_id_flush   = ctrl.if_id_flush;
   assign bus.o_id_ex_en      = ctrl.id_ex_en;
   assign bus.o_id_ex_bubble  = ctrl.id_ex_bubble;
   assign bus.o_ex_mem_en     = ctrl.ex_mem_en;
   assign bus.o_mem_wb_en     = ctrl.mem_wb_en;
   assign bus.o_mem_wb_bubble = ctrl.mem_wb_bubble;
   assign bus.o_state         = state_q;

   assign stall_inc = (state_q != S_RESET) & ~ctrl.pc_en;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_inc   (stall_inc),
      .o_count (bus.o_stall_cycles)
   );

endmodule
